mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle control unit for the ARM-subset datapath: decodes the instruction held in the instruction register, sequences the datapath through a per-instruction state sequence, and owns the architectural NZCV flags and condition evaluation. It drives every select/enable input of the datapath and the memory write enable, and sits beside the datapath under the processor top level.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Instr  in  20  Instr[31:12] from the instruction register: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the datapath ALU, this cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  data memory write enable
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  address select: 0=PC, 1=Result
- RegSrc  out  2  [0]: RA1=R15; [1]: RA2=Rd
- ALUSrcA  out  2  00=A, 01=PC, 10=ALUOut
- ALUSrcB  out  2  00=register WriteData, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  equals Op
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- Illegal  out  1  trap indication (see Configuration)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, TRAP.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=00 goes to EXECUTEI if Funct[5], else EXECUTER. Op=01 goes to MEMADR. Op=10 goes to BRANCH. Op=11 goes to TRAP or FETCH (see Configuration).
  - MEMADR→MEMRD if Funct[0], else MEMWR.
  - MEMRD→MEMWB. MEMWB, MEMWR, ALUWB and BRANCH all go to FETCH. EXECUTER and EXECUTEI go to ALUWB.
- Per-state controls. Anything not listed is 0/00, and ALU is ADD unless marked "op".
  - FETCH: AdrSrc0, IRWrite, ALUSrcA01, ALUSrcB10, ResultSrc10, NextPC.
  - DECODE: ALUSrcA01, ALUSrcB10, ResultSrc10.
  - MEMADR: ALUSrcA00, ALUSrcB01.
  - MEMRD: AdrSrc1, ResultSrc00.
  - MEMWB: ResultSrc01, RegW.
  - MEMWR: AdrSrc1, ResultSrc00, MemW.
  - EXECUTER: ALUSrcA00, ALUSrcB00, op.
  - EXECUTEI: ALUSrcA00, ALUSrcB01, op.
  - ALUWB: ResultSrc00, RegW.
  - BRANCH: ALUSrcA10, ALUSrcB01, ResultSrc10, Branch.
- ALU decode applies in op states only.
  - Funct[4:1] selects the operation: 0100=ADD, 0010=SUB, 0000=AND, 1100=ORR, anything else=ADD.
  - FlagW[1] (NZ) = Funct[0].
  - FlagW[0] (CV) = Funct[0] & (ADD|SUB).
  - FlagW=00 outside op states.
- RegSrc[0]=(Op==10). RegSrc[1]=(Op==01).
- Condition logic:
  - CondEx is a register captured at the DECODE→next edge from Cond and the flags register, and held until the next DECODE.
  - Codes follow standard ARM EQ..AL; 1111 evaluates false.
- Gated outputs:
  - RegWrite=RegW&CondEx. MemWrite=MemW&CondEx.
  - PCS=Branch|(RegW&Rd==15).
  - PCWrite=NextPC|(PCS&CondEx).
- Flags register: NZ updates from ALUFlags[3:2] on edges leaving an op state when FlagW[1]&CondEx; CV updates from ALUFlags[1:0] when FlagW[0]&CondEx.

## Timing
- All outputs are combinational from state, Instr and CondEx (Moore plus registered CondEx). There is no input-to-output path from ALUFlags.
- Reset asserted: state=FETCH, flags=0000, CondEx=0, Illegal=0. Outputs show FETCH values while in reset, which the datapath ignores because it is also in reset.
- Reset is recognised at any state. The first post-release edge completes FETCH.
- Latency in cycles: data-processing 4; LDR 5; STR 4; B 3. Failing condition uses the same cycle count with RegWrite, MemWrite and PC redirect suppressed.
- Flags written in EXECUTEx do not affect the CondEx of the same instruction.

## Configuration
- MC_CTRL_TRAP_EN defined:
  - Op=11, or an op-state Funct[4:1] outside the four supported codes, sends DECODE→TRAP.
  - TRAP is absorbing until reset: all enables 0, Illegal=1.
- MC_CTRL_TRAP_EN undefined:
  - Op=11 takes DECODE→FETCH as a NOP.
  - Unsupported Funct executes as ADD.
  - TRAP is unreachable and Illegal is tied 0.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum;
  - ALUControl codes;
  - ALUSrcA/ALUSrcB/ResultSrc select constants;
  - Op encodings;
  - condition-code constants.
- Sub-module mc_condlogic contains the flags register, CondEx register, condition evaluator and output gating. The FSM and decoder stay in the top level.

## Test plan
- ADD R1,R2,R3 (E0821003) → FETCH,DECODE,EXECUTER,ALUWB. ALUControl=00 in EXECUTER. RegWrite=1 only in ALUWB. PCWrite=1 only in FETCH.
- LDR R1,[R2,#4] (E5921004) → 5 states ending MEMWB, with ResultSrc=01 and RegWrite=1. STR (E5821004) → MemWrite=1 only in MEMWR, with AdrSrc=1.
- SUBS R0,R0,#1 (E2500001) with ALUFlags=0100 in EXECUTEI → flags=0100 after that edge. Following BEQ (0A000002) → PCWrite=1 in BRANCH.
- BEQ with Z=0 → PCWrite=0 in BRANCH, then FETCH. ADDEQ with Z=0 → RegWrite=0 in ALUWB, flags unchanged.
- ADD to R15 (E08FF003) → PCWrite=1 in ALUWB.
- Reset asserted in MEMRD → state=FETCH and flags=0000 immediately. With MC_CTRL_TRAP_EN, instruction EC000000 → TRAP, Illegal=1 held, all enables 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle control unit: state codes, datapath select
// encodings, ALU/opcode/condition codes and the ARM condition evaluator.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMRD    = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWR    = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_TRAP     = 4'd10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) || (cmd == CMD_ORR);
  endfunction

  // Code 1111 falls to the default and evaluates false.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = ~c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = ~n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = ~v;
      COND_HI: cond_eval = c & ~z;
      COND_LS: cond_eval = ~c | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = ~z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_condlogic.sv
// Flags register, registered condition result and gating of the write/redirect
// enables for the multicycle control unit.
module mc_condlogic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       capture,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       next_pc,
  output logic       pc_write_c,
  output logic       reg_write_c,
  output logic       mem_write_c
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       cond_ex_q, cond_ex_d;

  // CondEx samples the pre-execute flags, so an instruction's own S-update never gates itself.
  always_comb begin
    nz_d      = nz_q;
    cv_d      = cv_q;
    cond_ex_d = cond_ex_q;
    if (capture) cond_ex_d = cond_eval(cond, {nz_q, cv_q});
    if (flag_w[1] && cond_ex_q) nz_d = alu_flags[3:2];
    if (flag_w[0] && cond_ex_q) cv_d = alu_flags[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nz_q      <= 2'b00;
      cv_q      <= 2'b00;
      cond_ex_q <= 1'b0;
    end else begin
      nz_q      <= nz_d;
      cv_q      <= cv_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign reg_write_c = reg_w & cond_ex_q;
  assign mem_write_c = mem_w & cond_ex_q;
  assign pc_write_c  = next_pc | (pcs & cond_ex_q);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle ARM-subset control unit: state sequencer, instruction decoder and condition gating.
// Optional trap on Op=11 / unsupported data-processing command: define MC_CTRL_TRAP_EN.
module mc_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic        Illegal
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^Instr[7:4];

  state_t     state_q, state_d;
  logic       next_pc, branch, reg_w, mem_w, alu_op_en;
  logic       pcs, trap_req;
  logic [1:0] flag_w;

`ifdef MC_CTRL_TRAP_EN
  assign trap_req = (op == OP_SYS) || ((op == OP_DP) && !cmd_supported(cmd));
  assign Illegal  = (state_q == S_TRAP);
`else
  assign trap_req = 1'b0;
  assign Illegal  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and per-state datapath controls.
  always_comb begin
    state_d   = state_q;
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    alu_op_en = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        IRWrite   = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (trap_req) begin
          state_d = S_TRAP;
        end else begin
          case (op)
            OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        mem_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_op_en = 1'b1;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB   = SRCB_IMM;
        alu_op_en = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // ALU operation and flag-write mask, active only in the execute states.
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (alu_op_en) begin
      case (cmd)
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
      flag_w[1] = funct[0];
      flag_w[0] = funct[0] & ((cmd == CMD_ADD) || (cmd == CMD_SUB));
    end
  end

  assign ImmSrc = op;
  assign RegSrc = {op == OP_MEM, op == OP_BR};
  assign pcs    = branch | (reg_w & (rd == 4'd15));

  mc_condlogic u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (cond),
    .alu_flags  (ALUFlags),
    .flag_w     (flag_w),
    .capture    (state_q == S_DECODE),
    .pcs        (pcs),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .next_pc    (next_pc),
    .pc_write_c (PCWrite),
    .reg_write_c(RegWrite),
    .mem_write_c(MemWrite)
  );

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed instructions from the test plan plus a
// randomized instruction stream checked against an instruction-level model of flags and enables.
`timescale 1ns/1ps
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Illegal;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] mflags;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk       (clk),
    .reset     (reset),
    .Instr     (Instr),
    .ALUFlags  (ALUFlags),
    .PCWrite   (PCWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .RegSrc    (RegSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ImmSrc    (ImmSrc),
    .ALUControl(ALUControl),
    .Illegal   (Illegal)
  );

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one instruction from FETCH (entered just after a rising edge) to the next FETCH.
  task automatic run_instr(input logic [31:0] ins, input bit fixed, input logic [3:0] fflags,
                           input string tag);
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd, cmd, f_exec;
    logic [1:0] exp_alu, exp_res;
    logic [5:0] obs_en, exp_en;
    bit is_dp, is_ldr, is_str, is_b, pass, redirect, last;
    int len;
    op = ins[27:26]; funct = ins[25:20]; rd = ins[15:12]; cmd = funct[4:1];
    is_dp = (op == 2'd0); is_ldr = (op == 2'd1) && funct[0];
    is_str = (op == 2'd1) && !funct[0]; is_b = (op == 2'd2);
    len = is_dp ? 4 : is_ldr ? 5 : is_str ? 4 : is_b ? 3 : 2;
    pass = cond_holds(ins[31:28], mflags);
    redirect = is_b || ((is_dp || is_ldr) && rd == 4'd15);
    case (cmd)
      4'b0010: exp_alu = 2'b01;
      4'b0000: exp_alu = 2'b10;
      4'b1100: exp_alu = 2'b11;
      default: exp_alu = 2'b00;
    endcase
    f_exec = 4'h0;
    Instr = ins[31:12];
    for (int k = 0; k < len; k++) begin
      ALUFlags = fixed ? fflags : 4'($urandom);
      if (k == 2) f_exec = ALUFlags;
      last = (k == len - 1);
      @(negedge clk);
      obs_en = {IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, Illegal};
      exp_en = {k == 0, (k == 0) || (last && pass && redirect), last && pass && (is_dp || is_ldr),
                last && pass && is_str, (is_ldr || is_str) && k == 3, 1'b0};
      n_tests++;
      if (obs_en !== exp_en) begin
        n_fail++;
        $display("FAIL %s enables k=%0d {IR,PC,Reg,Mem,Adr,Ill} got %b exp %b", tag, k, obs_en, exp_en);
      end
      if (k > 0) begin
        n_tests++;
        if ({ImmSrc, RegSrc} !== {op, op == 2'd1, op == 2'd2}) begin
          n_fail++;
          $display("FAIL %s imm_regsrc k=%0d got %b exp %b", tag, k, {ImmSrc, RegSrc},
                   {op, op == 2'd1, op == 2'd2});
        end
      end
      if (k < 2) begin
        n_tests++;
        if ({ALUSrcA, ALUSrcB, ResultSrc} !== 6'b01_10_10) begin
          n_fail++;
          $display("FAIL %s pc_incr_sel k=%0d got %b exp 011010", tag, k, {ALUSrcA, ALUSrcB, ResultSrc});
        end
      end
      if (is_dp && k == 2) begin
        n_tests++;
        if ({ALUControl, ALUSrcA, ALUSrcB} !== {exp_alu, 2'b00, funct[5] ? 2'b01 : 2'b00}) begin
          n_fail++;
          $display("FAIL %s execute k=%0d {ALUCtl,SrcA,SrcB} got %b exp %b", tag, k,
                   {ALUControl, ALUSrcA, ALUSrcB}, {exp_alu, 2'b00, funct[5] ? 2'b01 : 2'b00});
        end
      end
      if (!is_dp && k >= 2) begin
        n_tests++;
        if (ALUControl !== 2'b00) begin
          n_fail++;
          $display("FAIL %s alu_add k=%0d got %b exp 00", tag, k, ALUControl);
        end
      end
      if (last && k >= 2) begin
        exp_res = is_ldr ? 2'b01 : is_b ? 2'b10 : 2'b00;
        n_tests++;
        if (ResultSrc !== exp_res) begin
          n_fail++;
          $display("FAIL %s resultsrc k=%0d got %b exp %b", tag, k, ResultSrc, exp_res);
        end
      end
      @(posedge clk); #1;
    end
    if (is_dp && pass && funct[0]) begin
      mflags[3:2] = f_exec[3:2];
      if (cmd == 4'b0100 || cmd == 4'b0010) mflags[1:0] = f_exec[1:0];
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    mflags = 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0; Instr = 20'h0; ALUFlags = 4'h0; mflags = 4'h0;
    #3;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, Illegal, ALUSrcA, ALUSrcB, ResultSrc}
          !== 12'b110000_01_10_10) begin
        n_fail++;
        $display("FAIL reset_outputs cycle=%0d got %b exp 110000011010", i,
                 {IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, Illegal, ALUSrcA, ALUSrcB, ResultSrc});
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    // Flags clear after reset: EQ fails, NE passes.
    run_instr(32'h0A000002, 1'b0, 4'h0, "reset_beq");
    run_instr(32'h1A000002, 1'b0, 4'h0, "reset_bne");
  endtask

  task automatic test_directed();
    run_instr(32'hE0821003, 1'b0, 4'h0, "add");
    run_instr(32'hE5921004, 1'b0, 4'h0, "ldr");
    run_instr(32'hE5821004, 1'b0, 4'h0, "str");
    run_instr(32'hE2500001, 1'b1, 4'b0100, "subs_z");
    run_instr(32'h0A000002, 1'b0, 4'h0, "beq_taken");
    run_instr(32'hE2500001, 1'b1, 4'b0000, "subs_nz");
    run_instr(32'h0A000002, 1'b0, 4'h0, "beq_not_taken");
    run_instr(32'h00821003, 1'b1, 4'b1111, "addeq_skip");
    run_instr(32'h0A000002, 1'b0, 4'h0, "beq_after_skip");
    run_instr(32'hE08FF003, 1'b0, 4'h0, "add_pc");
    run_instr(32'hE5921004 | 32'h0000F000, 1'b0, 4'h0, "ldr_pc");
  endtask

  task automatic test_reset_mid_instr();
    run_instr(32'hE2500001, 1'b1, 4'b0100, "pre_reset_subs");
    Instr = 20'hE5921;
    for (int i = 0; i < 3; i++) begin
      ALUFlags = 4'($urandom);
      @(posedge clk); #1;
    end
    n_tests++;
    if (AdrSrc !== 1'b1) begin
      n_fail++;
      $display("FAIL memrd_adrsrc got %b exp 1", AdrSrc);
    end
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if ({IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ResultSrc} !== 7'b11000_10) begin
      n_fail++;
      $display("FAIL async_reset_in_memrd got %b exp 1100010",
               {IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ResultSrc});
    end
    mflags = 4'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr(32'h0A000002, 1'b0, 4'h0, "post_reset_beq");
    run_instr(32'h1A000002, 1'b0, 4'h0, "post_reset_bne");
  endtask

  task automatic test_random();
    logic [3:0] cmds [4];
    logic [3:0] cond, rd, cmd;
    logic [1:0] op;
    logic [5:0] funct;
    logic [31:0] ins;
    int cls;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;
    for (int i = 0; i < 300; i++) begin
      cond = 4'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      cls = $urandom_range(0, 9);
`ifdef MC_CTRL_TRAP_EN
      if (cls == 9) cls = 0;
`endif
      funct = 6'($urandom);
      if (cls <= 4) begin
        op = 2'd0;
        cmd = cmds[$urandom_range(0, 3)];
`ifndef MC_CTRL_TRAP_EN
        if (cls == 4) begin
          cmd = 4'($urandom);
          if (!(cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100)) funct[0] = 1'b0;
        end
`endif
        funct[4:1] = cmd;
      end else if (cls <= 6) begin
        op = 2'd1;
      end else if (cls <= 8) begin
        op = 2'd2;
      end else begin
        op = 2'd3;
      end
      ins = {cond, op, funct, 4'($urandom), rd, 12'($urandom)};
      run_instr(ins, 1'b0, 4'h0, "random");
    end
  endtask

`ifdef MC_CTRL_TRAP_EN
  task automatic trap_one(input logic [31:0] ins, input string tag);
    Instr = ins[31:12];
    for (int k = 0; k < 8; k++) begin
      ALUFlags = 4'($urandom);
      @(negedge clk);
      n_tests++;
      if ({IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, Illegal} !== {k == 0, k == 0, 3'b000, k >= 2}) begin
        n_fail++;
        $display("FAIL %s k=%0d {IR,PC,Reg,Mem,Adr,Ill} got %b exp %b", tag, k,
                 {IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, Illegal}, {k == 0, k == 0, 3'b000, k >= 2});
      end
      @(posedge clk); #1;
      if (k == 4) Instr = 20'hE08FF;
    end
    do_reset();
  endtask

  task automatic test_trap();
    trap_one(32'hEC000000, "trap_op11");
    trap_one(32'hE0E21003, "trap_bad_cmd");
    run_instr(32'hE0821003, 1'b0, 4'h0, "after_trap_add");
  endtask
`else
  task automatic test_trap();
    run_instr(32'hEC000000, 1'b0, 4'h0, "nop_op11");
    run_instr(32'hE0E21003, 1'b0, 4'h0, "bad_cmd_as_add");
    run_instr(32'hE0821003, 1'b0, 4'h0, "after_nop_add");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_instr();
    test_trap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
